// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolver.
// Holds the resolver state encoding, the default flush length, the
// statistics counter width and a saturating-increment helper.
package branch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } br_state_e;

  localparam int FLUSH_CYCLES_DEF = 1;
  localparam int CNT_W            = 16;

  // Increment by one, holding at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// 16-bit saturating event counter with synchronous reset.
// Only compiled when BRANCH_STATS_EN is defined; the default build has no
// statistics logic at all.
`ifdef BRANCH_STATS_EN
module sat_counter
  import branch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count events, sticking at the maximum value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {CNT_W{1'b0}};
    end else if (inc) begin
      count <= sat_inc(count);
    end else begin
      count <= count;
    end
  end

endmodule
`endif

// File: rtl/branch_resolver.sv
// Branch resolver: turns a condition-passed ID-stage branch into a
// one-cycle PC redirect, a flush of FLUSH_CYCLES cycles and an optional
// link-register write. All outputs come straight from flops.
// Optional macro BRANCH_STATS_EN adds taken/not-taken saturating counters.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_valid,
  input  logic              br_link,
  input  logic              cond,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] pc_ret,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data,
  output logic              busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  nottaken_cnt
`endif
);

  // Cycles left in FLUSH after the first FLUSH cycle (FLUSH spans
  // FLUSH_CYCLES-1 cycles following the single REDIRECT cycle).
  localparam logic [1:0] FLUSH_LOAD = 2'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

  br_state_e   state_r;
  br_state_e   state_s;
  logic [1:0]  flush_cnt_r;
  logic [1:0]  flush_cnt_s;
  logic        capture_s;
  logic        taken_s;
  logic        pc_load_s;
  logic        flush_s;
  logic        link_we_s;
  logic        busy_s;

  // Branch capture only happens in IDLE when ID is not stalled.
  assign capture_s = (state_r == ST_IDLE) && br_valid && !stall;
  assign taken_s   = capture_s && cond;

  // State register and flush-length counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      flush_cnt_r <= 2'd0;
    end else begin
      state_r     <= state_s;
      flush_cnt_r <= flush_cnt_s;
    end
  end

  // Next-state logic: IDLE -> REDIRECT -> (FLUSH) -> IDLE.
  always_comb begin
    state_s     = state_r;
    flush_cnt_s = flush_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (taken_s) begin
          state_s = ST_REDIRECT;
        end else begin
          state_s = ST_IDLE;
        end
        flush_cnt_s = 2'd0;
      end
      ST_REDIRECT: begin
        if (FLUSH_CYCLES > 1) begin
          state_s     = ST_FLUSH;
          flush_cnt_s = FLUSH_LOAD;
        end else begin
          state_s     = ST_IDLE;
          flush_cnt_s = 2'd0;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_r == 2'd0) begin
          state_s     = ST_IDLE;
          flush_cnt_s = 2'd0;
        end else begin
          state_s     = ST_FLUSH;
          flush_cnt_s = flush_cnt_r - 2'd1;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        flush_cnt_s = 2'd0;
      end
    endcase
  end

  // Output decode of the upcoming state, registered below so outputs are
  // flop-driven and line up with the state they describe.
  always_comb begin
    pc_load_s = 1'b0;
    flush_s   = 1'b0;
    link_we_s = 1'b0;
    busy_s    = 1'b0;
    case (state_s)
      ST_IDLE: begin
        pc_load_s = 1'b0;
        flush_s   = 1'b0;
        link_we_s = 1'b0;
        busy_s    = 1'b0;
      end
      ST_REDIRECT: begin
        pc_load_s = 1'b1;
        flush_s   = 1'b1;
        link_we_s = br_link;  // REDIRECT is only ever entered from a capture
        busy_s    = 1'b1;
      end
      ST_FLUSH: begin
        pc_load_s = 1'b0;
        flush_s   = 1'b1;
        link_we_s = 1'b0;
        busy_s    = 1'b1;
      end
      default: begin
        pc_load_s = 1'b0;
        flush_s   = 1'b0;
        link_we_s = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
  end

  // Output flops; target and return address hold until the next taken capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_load   <= 1'b0;
      flush     <= 1'b0;
      link_we   <= 1'b0;
      busy      <= 1'b0;
      pc_target <= {ADDR_W{1'b0}};
      link_data <= {ADDR_W{1'b0}};
    end else begin
      pc_load <= pc_load_s;
      flush   <= flush_s;
      link_we <= link_we_s;
      busy    <= busy_s;
      if (taken_s) begin
        pc_target <= br_target;
        link_data <= pc_ret;
      end else begin
        pc_target <= pc_target;
        link_data <= link_data;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic nottaken_s;
  assign nottaken_s = capture_s && !cond;

  sat_counter u_taken_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (taken_s),
    .count (taken_cnt)
  );

  sat_counter u_nottaken_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (nottaken_s),
    .count (nottaken_cnt)
  );
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: two instances (FLUSH_CYCLES 1 and 3)
// share one randomized stimulus stream; a cycle-count reference model
// predicts each one, and redirects are queued and matched on pc_load.
module tb_branch_resolver;
  import branch_pkg::*;

  localparam int AW = 32;

  typedef struct {
    logic [AW-1:0] tgt;
    logic          lnk;
    logic [AW-1:0] ret;
  } redir_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, stall, br_valid, br_link, cond;
  logic [AW-1:0] br_target, pc_ret;

  logic          pl[2], fl[2], lw[2], bz[2];
  logic [AW-1:0] tg[2], ld[2];
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] tc[2], nc[2];
`endif

  branch_resolver #(.ADDR_W(AW), .FLUSH_CYCLES(1)) u_dut_f1 (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
    .br_link(br_link), .cond(cond), .br_target(br_target), .pc_ret(pc_ret),
    .pc_load(pl[0]), .pc_target(tg[0]), .flush(fl[0]), .link_we(lw[0]),
    .link_data(ld[0]), .busy(bz[0])
`ifdef BRANCH_STATS_EN
    , .taken_cnt(tc[0]), .nottaken_cnt(nc[0])
`endif
  );

  branch_resolver #(.ADDR_W(AW), .FLUSH_CYCLES(3)) u_dut_f3 (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
    .br_link(br_link), .cond(cond), .br_target(br_target), .pc_ret(pc_ret),
    .pc_load(pl[1]), .pc_target(tg[1]), .flush(fl[1]), .link_we(lw[1]),
    .link_data(ld[1]), .busy(bz[1])
`ifdef BRANCH_STATS_EN
    , .taken_cnt(tc[1]), .nottaken_cnt(nc[1])
`endif
  );

  // Reference model: each instance is busy for exactly fc cycles after a
  // taken capture; the first of those cycles is the redirect.
  int            fcs[2] = '{1, 3};
  int            rem[2];
  logic          exp_pl[2], exp_lw[2];
  logic [AW-1:0] exp_tgt[2], exp_ret[2];
  int            tk[2], nt[2];
  redir_t        q0[$], q1[$];

  int   n_cmp  = 0;
  int   n_fail = 0;
  logic chk_en = 1'b0;

  task automatic cmp(input string name, input int idx, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[fc=%0d] @%0t: got %h, expected %h", name, fcs[idx], $time, act, exp);
    end
  endtask

  // Model update on each active edge using the inputs just sampled.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      redir_t e;
      if (reset) begin
        rem[i] = 0; exp_pl[i] = 1'b0; exp_lw[i] = 1'b0;
        exp_tgt[i] = '0; exp_ret[i] = '0; tk[i] = 0; nt[i] = 0;
        if (i == 0) q0.delete(); else q1.delete();
      end else if (rem[i] > 0) begin
        rem[i]--; exp_pl[i] = 1'b0; exp_lw[i] = 1'b0;
      end else begin
        exp_pl[i] = 1'b0; exp_lw[i] = 1'b0;
        if (br_valid && !stall) begin
          if (cond) begin
            rem[i] = fcs[i]; exp_pl[i] = 1'b1; exp_lw[i] = br_link;
            exp_tgt[i] = br_target; exp_ret[i] = pc_ret;
            if (tk[i] < 65535) tk[i]++;
            e.tgt = br_target; e.lnk = br_link; e.ret = pc_ret;
            if (i == 0) q0.push_back(e); else q1.push_back(e);
          end else begin
            if (nt[i] < 65535) nt[i]++;
          end
        end
      end
    end
  end

  // Monitor: per-cycle output check plus redirect scoreboard on pc_load.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        redir_t e;
        cmp("pc_load", i, AW'(pl[i]), AW'(exp_pl[i]));
        cmp("flush", i, AW'(fl[i]), AW'(rem[i] > 0));
        cmp("busy", i, AW'(bz[i]), AW'(rem[i] > 0));
        cmp("link_we", i, AW'(lw[i]), AW'(exp_lw[i]));
        cmp("pc_target", i, tg[i], exp_tgt[i]);
        cmp("link_data", i, ld[i], exp_ret[i]);
`ifdef BRANCH_STATS_EN
        cmp("taken_cnt", i, AW'(tc[i]), AW'(tk[i]));
        cmp("nottaken_cnt", i, AW'(nc[i]), AW'(nt[i]));
`endif
        if (pl[i] === 1'b1) begin
          if ((i == 0 ? q0.size() : q1.size()) == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL redirect_unexpected[fc=%0d] @%0t: pc_load with no queued branch", fcs[i], $time);
          end else begin
            if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
            cmp("sb_target", i, tg[i], e.tgt);
            cmp("sb_link_we", i, AW'(lw[i]), AW'(e.lnk));
            cmp("sb_link_data", i, ld[i], e.ret);
          end
        end
      end
    end
  end

  task automatic drive(input logic rst, input logic v, input logic l, input logic c,
                       input logic s, input logic [AW-1:0] t, input logic [AW-1:0] r);
    reset = rst; br_valid = v; br_link = l; cond = c; stall = s;
    br_target = t; pc_ret = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; br_valid = 1'b0; br_link = 1'b0; cond = 1'b0;
    br_target = '0; pc_ret = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(2);
    // taken plain branch
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000);
    idle(4);
    // taken branch-with-link
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0104);
    idle(4);
    // not taken
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0000_0204);
    idle(2);
    // branches offered while busy
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_0000);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_0504);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0000_0604);
    idle(5);
    // stall blocks capture, release redirects next cycle
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0700, 32'h0000_0000);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0700, 32'h0000_0000);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0700, 32'h0000_0000);
    idle(4);
    // reset in the 2nd flush cycle of the fc=3 instance
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0800, 32'h0000_0804);
    idle(1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(3);
    // reset beats a simultaneous capture
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0900, 32'h0000_0904);
    idle(3);
    // randomized traffic
    for (int k = 0; k < 800; k++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0),
            1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
            AW'($urandom), AW'($urandom));
    end
    idle(6);
    chk_en = 1'b0;
    cmp("sb_drain", 0, AW'(q0.size()), AW'(0));
    cmp("sb_drain", 1, AW'(q1.size()), AW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter: ADDR_W, default 32, width of branch target and return address.
REQ-002 Parameter: FLUSH_CYCLES, default 1, legal 1..3, total cycles `flush` is asserted per taken branch.
REQ-003 Port: clk  input  1  rising-edge clock; one clock domain.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: stall  input  1  hazard stall from the ID stage; blocks branch capture.
REQ-006 Port: br_valid  input  1  ID-stage instruction is a branch.
REQ-007 Port: br_link  input  1  branch is branch-with-link.
REQ-008 Port: cond  input  1  condition-pass result from the condition tester for the ID-stage instruction.
REQ-009 Port: br_target  input  ADDR_W  computed branch target.
REQ-010 Port: pc_ret  input  ADDR_W  return address for link.
REQ-011 Port: pc_load  output  1  PC loads `pc_target` this cycle.
REQ-012 Port: pc_target  output  ADDR_W  registered branch target.
REQ-013 Port: flush  output  1  squash IF/ID contents.
REQ-014 Port: link_we  output  1  write `link_data` to the link register.
REQ-015 Port: link_data  output  ADDR_W  registered return address.
REQ-016 Port: busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 States: IDLE, REDIRECT, FLUSH; all outputs are driven from registered state only.
REQ-018 Capture: at a rising edge in IDLE with br_valid=1 and stall=0, the block samples cond.
REQ-019 Taken capture (cond=1): next state is REDIRECT; the block latches pc_target<=br_target, link_data<=pc_ret and the br_link value.
REQ-020 Not-taken capture (cond=0): the block stays in IDLE; pc_load, flush and link_we stay 0.
REQ-021 REDIRECT lasts exactly 1 cycle, with pc_load=1, flush=1 and link_we equal to the latched br_link.
REQ-022 Exit from REDIRECT: go to FLUSH if FLUSH_CYCLES>1, otherwise to IDLE.
REQ-023 FLUSH lasts FLUSH_CYCLES-1 cycles, with flush=1, pc_load=0 and link_we=0; then the block returns to IDLE.
REQ-024 Latency: pc_load rises exactly 1 cycle after the capturing edge; pc_load and link_we are single-cycle pulses.
REQ-025 While busy=1, br_valid, cond and br_link are ignored; back-to-back branches are not captured.
REQ-026 stall has no effect in REDIRECT or FLUSH; redirect has priority over stall.
REQ-027 pc_target and link_data hold their values until the next taken capture.

Reset
REQ-028 When reset=1 at an edge, state<=IDLE; pc_load, flush, link_we and busy are 0; pc_target and link_data are 0.
REQ-029 Reset asserted in REDIRECT or FLUSH aborts the sequence at once, and the next cycle outputs the reset values.
REQ-030 Reset overrides a simultaneous capture; no branch is recorded.

Configuration
REQ-031 Macro BRANCH_STATS_EN: when defined, adds the output ports taken_cnt (16) and nottaken_cnt (16).
REQ-032 taken_cnt increments on each taken capture and nottaken_cnt on each not-taken capture.
REQ-033 Both counters saturate at 16'hFFFF and are cleared by reset.
REQ-034 When BRANCH_STATS_EN is undefined, these ports and counters do not exist, and all other behaviour is identical.

Structure
REQ-035 Shared package branch_pkg holds the state enum typedef, the FLUSH_CYCLES default and the counter width constant.
REQ-036 One sub-module, sat_counter (16-bit saturating incrementer with sync reset), is instantiated twice under BRANCH_STATS_EN.

Verification
REQ-037 Taken plain branch: br_valid=1, cond=1, br_link=0, br_target=32'h0000_0040 -> next cycle pc_load=1, flush=1, pc_target=32'h40, link_we=0; IDLE after.
REQ-038 Taken BL: br_link=1, pc_ret=32'h0000_0104 -> link_we=1 and link_data=32'h104 in the same cycle as pc_load.
REQ-039 Not taken: cond=0 -> pc_load, flush and busy remain 0; with BRANCH_STATS_EN, nottaken_cnt 0->1.
REQ-040 FLUSH_CYCLES=3: taken branch -> flush high 3 cycles, pc_load high only the first; br_valid=1 during busy is ignored.
REQ-041 Stall: br_valid=1, cond=1, stall=1 -> no capture; deassert stall -> redirect follows 1 cycle later.
REQ-042 Reset mid-FLUSH with FLUSH_CYCLES=3: reset in the 2nd flush cycle -> next cycle flush=0, busy=0, pc_target=0.
